i2c_config_sequencer: RTL and testbench
=======================================

Name: i2c_config_sequencer

Overview:
- Boot-time configuration controller for the WM8731 codec (microphone input path) on the 20 kHz I2C clock domain.
- Walks an internal 8-entry table of {reg_addr, write_data} pairs and issues one I2C write per entry through the i2c_master valid/ready write handshake.
- Checks the master's error (NACK) flag after each transfer, retries a failing entry, and reports done/fail to the audio pipeline.
- Sits between top-level reset/start logic and i2c_master; it is the only requester driving i2c_master.

Parameters:
SLAVE_ADDR, 7'h1A, 7-bit I2C address of the codec, driven on i2c_slav_addr.
MAX_RETRIES, 3, extra attempts per entry after a NACK or timeout (0 = no retry).
GAP_CYCLES, 4, idle clk cycles between consecutive transfers (min 1).
TIMEOUT_CYCLES, 64, clk cycles allowed from handshake to transfer completion.

Ports:
clk  in  1  20 kHz clock, shared with i2c_master.
reset  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse; (re)starts the sequence from entry 0.
i2c_slav_addr  out  7  constant SLAVE_ADDR.
i2c_read_not_write  out  1  constant 0 (write only).
i2c_reg_addr  out  8  reg_addr of current entry.
i2c_write_data  out  8  write_data of current entry.
i2c_write_valid  out  1  request to i2c_master.
i2c_write_ready  in  1  i2c_master ready (high only while the master is idle).
i2c_error  in  1  i2c_master NACK flag.
busy  out  1  sequence in progress.
done  out  1  all entries written OK; sticky.
fail  out  1  entry exhausted its retries; sticky.
cmd_index  out  3  index of the current or failing entry.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except i2c_slav_addr=SLAVE_ADDR; retry count=0; gap and timeout counters=0.
- Table, fixed, index: reg_addr, data:
  - 0: 0x1E, 0x00 (reset)
  - 1: 0x00, 0x17
  - 2: 0x08, 0x15
  - 3: 0x0A, 0x00
  - 4: 0x0C, 0x00
  - 5: 0x0E, 0x42
  - 6: 0x10, 0x00
  - 7: 0x12, 0x01 (activate)
- States: IDLE, REQ, WAIT_BUSY, WAIT_DONE, CHECK, GAP, DONE, FAIL.
- Transitions:
  - IDLE: start -> REQ with index=0, retries=0, done=0, fail=0.
  - REQ: i2c_write_valid=1 combinationally, payload stable. Handshake = valid & ready in the same cycle -> WAIT_BUSY. Valid is low in every other state.
  - WAIT_BUSY: wait for i2c_write_ready=0 -> WAIT_DONE. Ready low on the first cycle after the handshake is normal.
  - WAIT_DONE: wait for i2c_write_ready to return to 1 -> CHECK.
  - CHECK: one cycle; sample i2c_error on this first cycle of returned ready, because the master clears its ACK flags at the end of that cycle.
    - Error=0: index==7 -> DONE, else index+1, retries=0 -> GAP.
    - Error=1: retries<MAX_RETRIES -> retries+1 -> GAP, same index; else -> FAIL.
  - GAP: count GAP_CYCLES -> REQ.
  - DONE: done=1, busy=0; start -> restart as from IDLE.
  - FAIL: fail=1, busy=0, cmd_index holds the failing entry; start -> restart.
- Timeout: a counter runs in WAIT_BUSY and WAIT_DONE and clears on entry to REQ. Reaching TIMEOUT_CYCLES is treated exactly as error=1 in CHECK (retry or FAIL).
- busy=1 in REQ through GAP.
- start while busy is ignored.
- Nominal transfer ≈ 30 clk. Sequence with no errors ≈ 8*(32+GAP_CYCLES) clk.
- Reset mid-transfer: the sequencer returns to IDLE immediately. i2c_master is not reset by this block; a later start waits in REQ until ready returns.

Optional Feature:
I2C_CFG_AUTOSTART_EN: if defined, the sequence self-starts on the first clk edge after reset deasserts, behaving as an internal start pulse; the start port still allows re-runs. If undefined, the block stays in IDLE until start.

Test Plan:
- Behavioural i2c_master model, always ACK; start pulse -> 8 handshakes with payloads exactly per the table in order, (0x1E,0x00) first, (0x12,0x01) last; done=1, busy=0, fail=0.
- Model NACKs entry 3 once -> entry 3 handshake seen twice, GAP_CYCLES between; done=1, 9 handshakes total.
- Model NACKs entry 5 always, MAX_RETRIES=3 -> 4 attempts at entry 5; then fail=1, cmd_index=5, no further handshakes; start -> restarts at entry 0.
- Model holds ready low after handshake on entry 2 -> timeout after 64 clk counts as error and triggers a retry; release the hold -> completes with done=1.
- Assert reset during WAIT_DONE of entry 4 -> valid=0, busy=0, done=0, fail=0 immediately (asynchronous); also start pulse while busy -> no effect on index.
- With I2C_CFG_AUTOSTART_EN defined, release reset and never pulse start -> entry-0 handshake occurs; done=1 at the end.

Source files
------------

// File: rtl/i2c_config_sequencer.sv
// Boot-time WM8731 configuration sequencer: writes an 8-entry register table through i2c_master.
// Optional I2C_CFG_AUTOSTART_EN: the sequence starts on the first clk edge after reset release.
module i2c_config_sequencer #(
    parameter logic [6:0]  SLAVE_ADDR     = 7'h1A,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [6:0] i2c_slav_addr,
    output logic       i2c_read_not_write,
    output logic [7:0] i2c_reg_addr,
    output logic [7:0] i2c_write_data,
    output logic       i2c_write_valid,
    input  logic       i2c_write_ready,
    input  logic       i2c_error,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [2:0] cmd_index
);

    localparam int unsigned RetryW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TmoW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);
    localparam logic [GapW-1:0]   GapLast  = GapW'(GAP_CYCLES - 1);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StReq, StWaitBusy, StWaitDone, StCheck, StGap, StDone, StFail
    } state_e;

    state_e            state_q;
    logic [2:0]        index_q;
    logic [RetryW-1:0] retry_q;
    logic [GapW-1:0]   gap_q;
    logic [TmoW-1:0]   tmo_q;
    logic              err_q;
    logic              busy_q;
    logic              done_q;
    logic              fail_q;
    logic [7:0]        addr_q;
    logic [7:0]        data_q;
    logic              start_go;

    // {reg_addr, write_data}
    function automatic logic [15:0] table_entry(input logic [2:0] idx);
        logic [15:0] e;
        case (idx)
            3'd0:    e = {8'h1E, 8'h00};
            3'd1:    e = {8'h00, 8'h17};
            3'd2:    e = {8'h08, 8'h15};
            3'd3:    e = {8'h0A, 8'h00};
            3'd4:    e = {8'h0C, 8'h00};
            3'd5:    e = {8'h0E, 8'h42};
            3'd6:    e = {8'h10, 8'h00};
            default: e = {8'h12, 8'h01};
        endcase
        return e;
    endfunction

`ifdef I2C_CFG_AUTOSTART_EN
    logic auto_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            auto_q <= 1'b1;
        end else begin
            auto_q <= 1'b0;
        end
    end

    assign start_go = start | auto_q;
`else
    assign start_go = start;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            index_q <= 3'd0;
            retry_q <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            case (state_q)
                StIdle, StDone, StFail: begin
                    if (start_go) begin
                        state_q          <= StReq;
                        index_q          <= 3'd0;
                        retry_q          <= '0;
                        tmo_q            <= '0;
                        err_q            <= 1'b0;
                        busy_q           <= 1'b1;
                        done_q           <= 1'b0;
                        fail_q           <= 1'b0;
                        {addr_q, data_q} <= table_entry(3'd0);
                    end
                end
                StReq: begin
                    if (i2c_write_ready) begin
                        state_q <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (!i2c_write_ready) begin
                        state_q <= StWaitDone;
                    end else if (tmo_q == TmoLast) begin
                        err_q   <= 1'b1;
                        state_q <= StCheck;
                    end
                end
                StWaitDone: begin
                    tmo_q <= tmo_q + 1'b1;
                    // The NACK flag is only valid on the first cycle ready is back.
                    if (i2c_write_ready) begin
                        err_q   <= i2c_error;
                        state_q <= StCheck;
                    end else if (tmo_q == TmoLast) begin
                        err_q   <= 1'b1;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    gap_q <= '0;
                    if (!err_q) begin
                        if (index_q == 3'd7) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            index_q <= index_q + 3'd1;
                            retry_q <= '0;
                            state_q <= StGap;
                        end
                    end else if (retry_q < RetryMax) begin
                        retry_q <= retry_q + 1'b1;
                        state_q <= StGap;
                    end else begin
                        state_q <= StFail;
                        busy_q  <= 1'b0;
                        fail_q  <= 1'b1;
                    end
                end
                StGap: begin
                    if (gap_q == GapLast) begin
                        gap_q            <= '0;
                        tmo_q            <= '0;
                        err_q            <= 1'b0;
                        state_q          <= StReq;
                        {addr_q, data_q} <= table_entry(index_q);
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign i2c_slav_addr      = SLAVE_ADDR;
    assign i2c_read_not_write = 1'b0;
    assign i2c_reg_addr       = addr_q;
    assign i2c_write_data     = data_q;
    assign i2c_write_valid    = (state_q == StReq);
    assign busy               = busy_q;
    assign done               = done_q;
    assign fail               = fail_q;
    assign cmd_index          = index_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer with a behavioural i2c_master that can NACK or stall.
module tb_i2c_config_sequencer;

    localparam int XFER = 6;  // master busy cycles per transfer in this model
    localparam int GAP  = 4;
    localparam int HS_PERIOD = XFER + GAP + 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b1;
    logic       err = 1'b0;
    logic [6:0] slav;
    logic       rnw;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       valid;
    logic       busy;
    logic       done;
    logic       fail;
    logic [2:0] cmd_idx;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] tb_addr [8] = '{8'h1E, 8'h00, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h12};
    logic [7:0] tb_data [8] = '{8'h00, 8'h17, 8'h15, 8'h00, 8'h00, 8'h42, 8'h00, 8'h01};

    logic [7:0] hs_addr [$];
    logic [7:0] hs_data [$];
    int         hs_cyc [$];

    int cyc = 0;
    int nack_entry = -1;
    int nack_left = 0;
    int hold_entry = -1;
    int hold_left = 0;
    bit hold = 0;
    bit nack_now = 0;
    bit pending = 0;
    bit in_xfer = 0;
    int busy_cnt = 0;

    i2c_config_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .i2c_slav_addr      (slav),
        .i2c_read_not_write (rnw),
        .i2c_reg_addr       (reg_addr),
        .i2c_write_data     (wdata),
        .i2c_write_valid    (valid),
        .i2c_write_ready    (ready),
        .i2c_error          (err),
        .busy               (busy),
        .done               (done),
        .fail               (fail),
        .cmd_index          (cmd_idx)
    );

    always #5 clk = ~clk;

    function automatic int entry_of(input logic [7:0] a);
        for (int i = 0; i < 8; i++) begin
            if (tb_addr[i] == a) return i;
        end
        return -1;
    endfunction

    // Master model: acts on negedges; ready drops after a handshake, returns with the ACK result.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            cyc++;
            err = 1'b0;
            if (pending) begin
                pending  = 0;
                ready    = 1'b0;
                in_xfer  = 1;
                busy_cnt = XFER;
            end else if (in_xfer) begin
                if (!hold && busy_cnt == 0) begin
                    ready   = 1'b1;
                    err     = nack_now;
                    in_xfer = 0;
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                end
            end else if (ready && valid) begin
                hs_addr.push_back(reg_addr);
                hs_data.push_back(wdata);
                hs_cyc.push_back(cyc);
                e = entry_of(reg_addr);
                nack_now = (e == nack_entry && nack_left > 0);
                if (nack_now) nack_left--;
                if (e == hold_entry && hold_left > 0) begin
                    hold = 1;
                    hold_left--;
                end
                pending = 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_log();
        hs_addr.delete();
        hs_data.delete();
        hs_cyc.delete();
    endtask

    task automatic wait_end(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            tick(1);
            if (done || fail) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_hs(input int n, input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            tick(1);
            if (hs_addr.size() >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick(3);
        compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", valid); end
        compared++; if ({busy, done, fail} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got %b want 000", {busy, done, fail}); end
        compared++; if (cmd_idx !== 3'd0) begin mismatched++; $display("FAIL reset_index: got %0d want 0", cmd_idx); end
        compared++; if ({reg_addr, wdata} !== 16'h0000) begin mismatched++; $display("FAIL reset_payload: got %h want 0000", {reg_addr, wdata}); end
        compared++; if ({slav, rnw} !== {7'h1A, 1'b0}) begin mismatched++; $display("FAIL reset_const: got %h/%b want 1a/0", slav, rnw); end
        @(negedge clk);
        reset = 1'b0;
`ifndef I2C_CFG_AUTOSTART_EN
        tick(5);
        compared++; if (busy !== 1'b0 || hs_addr.size() != 0) begin mismatched++; $display("FAIL idle_no_start: busy %b hs %0d want 0/0", busy, hs_addr.size()); end
`endif
    endtask

    task automatic test_autostart();
        bit ok;
        wait_hs(1, 200, ok);
        compared++; if (!ok || hs_addr[0] !== 8'h1E) begin mismatched++; $display("FAIL autostart_first: ok %b addr %h want 1e", ok, ok ? hs_addr[0] : 8'h00); end
        wait_end(2000, ok);
        compared++; if (!ok || done !== 1'b1) begin mismatched++; $display("FAIL autostart_done: ok %b done %b want 1", ok, done); end
        compared++; if (hs_addr.size() != 8) begin mismatched++; $display("FAIL autostart_count: got %0d want 8", hs_addr.size()); end
    endtask

    task automatic test_nominal();
        bit ok;
        logic [7:0] a, d;
        clear_log();
        pulse_start();
        wait_end(2000, ok);
        compared++; if (!ok || {done, fail, busy} !== 3'b100) begin mismatched++; $display("FAIL nom_flags: ok %b dfb %b want 100", ok, {done, fail, busy}); end
        compared++; if (hs_addr.size() != 8) begin mismatched++; $display("FAIL nom_count: got %0d want 8", hs_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            a = (i < hs_addr.size()) ? hs_addr[i] : 8'hxx;
            d = (i < hs_data.size()) ? hs_data[i] : 8'hxx;
            compared++;
            if (a !== tb_addr[i] || d !== tb_data[i]) begin
                mismatched++;
                $display("FAIL nom_entry%0d: got %h,%h want %h,%h", i, a, d, tb_addr[i], tb_data[i]);
            end
        end
        compared++; if (hs_cyc.size() == 8 && hs_cyc[7] - hs_cyc[0] != 7 * HS_PERIOD) begin mismatched++; $display("FAIL nom_spacing: got %0d want %0d", hs_cyc[7] - hs_cyc[0], 7 * HS_PERIOD); end
        compared++; if (cmd_idx !== 3'd7) begin mismatched++; $display("FAIL nom_index: got %0d want 7", cmd_idx); end
    endtask

    task automatic test_nack_once();
        bit ok;
        logic [7:0] a;
        int exp_seq [9];
        exp_seq = '{0, 1, 2, 3, 3, 4, 5, 6, 7};
        nack_entry = 3;
        nack_left = 1;
        clear_log();
        pulse_start();
        wait_end(2000, ok);
        compared++; if (!ok || {done, fail} !== 2'b10) begin mismatched++; $display("FAIL nack1_flags: ok %b df %b want 10", ok, {done, fail}); end
        compared++; if (hs_addr.size() != 9) begin mismatched++; $display("FAIL nack1_count: got %0d want 9", hs_addr.size()); end
        for (int i = 0; i < 9; i++) begin
            a = (i < hs_addr.size()) ? hs_addr[i] : 8'hxx;
            compared++;
            if (a !== tb_addr[exp_seq[i]]) begin
                mismatched++;
                $display("FAIL nack1_seq%0d: got %h want %h", i, a, tb_addr[exp_seq[i]]);
            end
        end
        compared++; if (hs_cyc.size() >= 5 && hs_cyc[4] - hs_cyc[3] != HS_PERIOD) begin mismatched++; $display("FAIL nack1_gap: got %0d want %0d", hs_cyc[4] - hs_cyc[3], HS_PERIOD); end
        nack_entry = -1;
    endtask

    task automatic test_nack_fail();
        bit ok;
        logic [7:0] a;
        int exp_seq [9];
        exp_seq = '{0, 1, 2, 3, 4, 5, 5, 5, 5};
        nack_entry = 5;
        nack_left = 1000;
        clear_log();
        pulse_start();
        wait_end(2000, ok);
        compared++; if (!ok || {fail, done, busy} !== 3'b100) begin mismatched++; $display("FAIL nackf_flags: ok %b fdb %b want 100", ok, {fail, done, busy}); end
        compared++; if (cmd_idx !== 3'd5) begin mismatched++; $display("FAIL nackf_index: got %0d want 5", cmd_idx); end
        for (int i = 0; i < 9; i++) begin
            a = (i < hs_addr.size()) ? hs_addr[i] : 8'hxx;
            compared++;
            if (a !== tb_addr[exp_seq[i]]) begin
                mismatched++;
                $display("FAIL nackf_seq%0d: got %h want %h", i, a, tb_addr[exp_seq[i]]);
            end
        end
        tick(100);
        compared++; if (hs_addr.size() != 9 || fail !== 1'b1) begin mismatched++; $display("FAIL nackf_quiet: hs %0d fail %b want 9/1", hs_addr.size(), fail); end
        nack_entry = -1;
        clear_log();
        pulse_start();
        compared++; if ({fail, busy} !== 2'b01) begin mismatched++; $display("FAIL nackf_restart: fb %b want 01", {fail, busy}); end
        wait_end(2000, ok);
        compared++; if (!ok || done !== 1'b1 || hs_addr.size() != 8) begin mismatched++; $display("FAIL nackf_rerun: done %b hs %0d want 1/8", done, hs_addr.size()); end
        compared++; if (hs_addr.size() == 0 || hs_addr[0] !== 8'h1E) begin mismatched++; $display("FAIL nackf_rerun_first: want addr 1e"); end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [7:0] a;
        int exp_seq [9];
        exp_seq = '{0, 1, 2, 2, 3, 4, 5, 6, 7};
        hold_entry = 2;
        hold_left = 1;
        clear_log();
        pulse_start();
        wait_hs(3, 500, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL tmo_reach: hs %0d want 3", hs_addr.size()); end
        tick(61);
        compared++; if ({valid, busy} !== 2'b01) begin mismatched++; $display("FAIL tmo_waiting: vb %b want 01", {valid, busy}); end
        tick(10);
        compared++; if (valid !== 1'b1 || hs_addr.size() != 3) begin mismatched++; $display("FAIL tmo_retry_req: valid %b hs %0d want 1/3", valid, hs_addr.size()); end
        hold = 0;
        hold_entry = -1;
        wait_end(2000, ok);
        compared++; if (!ok || {done, fail} !== 2'b10) begin mismatched++; $display("FAIL tmo_flags: ok %b df %b want 10", ok, {done, fail}); end
        for (int i = 0; i < 9; i++) begin
            a = (i < hs_addr.size()) ? hs_addr[i] : 8'hxx;
            compared++;
            if (a !== tb_addr[exp_seq[i]]) begin
                mismatched++;
                $display("FAIL tmo_seq%0d: got %h want %h", i, a, tb_addr[exp_seq[i]]);
            end
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear_log();
        pulse_start();
        wait_hs(4, 500, ok);
        compared++; if (!ok || cmd_idx !== 3'd3) begin mismatched++; $display("FAIL ign_pre: idx %0d want 3", cmd_idx); end
        pulse_start();
        tick(2);
        compared++; if (cmd_idx !== 3'd3 || busy !== 1'b1) begin mismatched++; $display("FAIL ign_post: idx %0d busy %b want 3/1", cmd_idx, busy); end
        wait_end(2000, ok);
        compared++; if (!ok || done !== 1'b1 || hs_addr.size() != 8) begin mismatched++; $display("FAIL ign_end: done %b hs %0d want 1/8", done, hs_addr.size()); end
        compared++; if (hs_addr.size() < 5 || hs_addr[4] !== 8'h0C) begin mismatched++; $display("FAIL ign_order: want entry 4 fifth"); end
    endtask

    task automatic test_reset_midxfer();
        bit ok;
        clear_log();
        pulse_start();
        wait_hs(5, 500, ok);
        tick(3);
        compared++; if (!ok || busy !== 1'b1) begin mismatched++; $display("FAIL rst_pre: ok %b busy %b want 1", ok, busy); end
        #2;
        reset = 1'b1;
        #1;
        compared++; if ({valid, busy, done, fail} !== 4'b0000) begin mismatched++; $display("FAIL rst_async: vbdf %b want 0000", {valid, busy, done, fail}); end
        compared++; if (cmd_idx !== 3'd0) begin mismatched++; $display("FAIL rst_index: got %0d want 0", cmd_idx); end
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        tick(1);
        pulse_start();
        wait_end(2000, ok);
        compared++; if (!ok || done !== 1'b1 || hs_addr.size() != 8) begin mismatched++; $display("FAIL rst_rerun: done %b hs %0d want 1/8", done, hs_addr.size()); end
        compared++; if (hs_addr.size() == 0 || hs_addr[0] !== 8'h1E) begin mismatched++; $display("FAIL rst_rerun_first: want addr 1e"); end
    endtask

    initial begin
        test_reset();
`ifdef I2C_CFG_AUTOSTART_EN
        test_autostart();
`endif
        test_nominal();
        test_nack_once();
        test_nack_fail();
        test_timeout();
        test_start_ignored();
        test_reset_midxfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
